// File: rtl/reg_file_flags.sv
// reg_file_flags: ALU operand register file with status-flag register.
//   2^D x W register array, one write port, two combinational read ports
//   with same-cycle write-to-read forwarding, Zero/Sign flag capture and a
//   saturating count of accepted register writes.
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   WrEn/WrAddr/WrData  register writeback
//   RdAddrA/RdAddrB     read indices; ReadA/ReadB combinational read data
//   FlagWr/ZeroIn/SignIn  flag capture; ZeroFlag/SignFlag registered flags
//   WrCount             saturating count of accepted writes
module reg_file_flags #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         WrEn,
  input  logic [D-1:0] WrAddr,
  input  logic [W-1:0] WrData,
  input  logic [D-1:0] RdAddrA,
  input  logic [D-1:0] RdAddrB,
  output logic [W-1:0] ReadA,
  output logic [W-1:0] ReadB,
  input  logic         FlagWr,
  input  logic         ZeroIn,
  input  logic         SignIn,
  output logic         ZeroFlag,
  output logic         SignFlag,
  output logic [7:0]   WrCount
);

  localparam int unsigned NREGS   = 1 << D;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0] regs [NREGS];

  // State update; reset drops any concurrent write or flag capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs     <= '{default: '0};
      ZeroFlag <= 1'b0;
      SignFlag <= 1'b0;
      WrCount  <= '0;
    end else begin
      if (WrEn) begin
        regs[WrAddr] <= WrData;
      end
      if (FlagWr) begin
        ZeroFlag <= ZeroIn;
        SignFlag <= SignIn;
      end
      if (WrEn && (WrCount != CNT_MAX)) begin
        WrCount <= WrCount + CNT_W'(1);
      end
    end
  end

  // Read ports bypass the array when the pending write targets the same index,
  // independently of Reset so dependent ops see the value in flight.
  always_comb begin
    ReadA = regs[RdAddrA];
    ReadB = regs[RdAddrB];
    if (WrEn && (WrAddr == RdAddrA)) begin
      ReadA = WrData;
    end
    if (WrEn && (WrAddr == RdAddrB)) begin
      ReadB = WrData;
    end
  end

endmodule

// File: tb/tb_reg_file_flags.sv
// Scoreboard bench for reg_file_flags: the driver applies one cycle of
// stimulus, pushes the expected outputs from a behavioural model, and a
// separate monitor pops and compares at each falling edge.
module tb_reg_file_flags;

  logic       Clk = 1'b0;
  logic       Reset, WrEn, FlagWr, ZeroIn, SignIn;
  logic [2:0] WrAddr, RdAddrA, RdAddrB;
  logic [7:0] WrData, ReadA, ReadB, WrCount;
  logic       ZeroFlag, SignFlag;

  reg_file_flags #(.W(8), .D(3)) dut (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .ReadA(ReadA), .ReadB(ReadB),
    .FlagWr(FlagWr), .ZeroIn(ZeroIn), .SignIn(SignIn),
    .ZeroFlag(ZeroFlag), .SignFlag(SignFlag), .WrCount(WrCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       z;
    logic       s;
    logic [7:0] c;
    string      nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mem [8];
  int m_cnt;
  bit m_z, m_s;

  task automatic chk(input string nm, input string field, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %02h expected %02h at %0t", nm, field, act, req, $time);
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations on falling edges.
  initial begin
    forever begin
      @(negedge Clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk(e.nm, "ReadA", ReadA, e.a);
        chk(e.nm, "ReadB", ReadB, e.b);
        chk(e.nm, "ZeroFlag", {7'd0, ZeroFlag}, {7'd0, e.z});
        chk(e.nm, "SignFlag", {7'd0, SignFlag}, {7'd0, e.s});
        chk(e.nm, "WrCount", WrCount, e.c);
      end
    end
  end

  // One clock cycle of stimulus; called right after a rising edge.
  task automatic cycle(input bit rst, input bit we, input int wa, input int wd,
                       input int ra, input int rb, input bit fw, input bit zi,
                       input bit si, input string nm);
    exp_t e;
    Reset = rst; WrEn = we; WrAddr = 3'(wa); WrData = 8'(wd);
    RdAddrA = 3'(ra); RdAddrB = 3'(rb); FlagWr = fw; ZeroIn = zi; SignIn = si;
    e.a  = 8'((we && wa == ra) ? wd : m_mem[ra]);
    e.b  = 8'((we && wa == rb) ? wd : m_mem[rb]);
    e.z  = m_z;
    e.s  = m_s;
    e.c  = 8'(m_cnt);
    e.nm = nm;
    q.push_back(e);
    @(posedge Clk);
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_z = 0; m_s = 0; m_cnt = 0;
    end else begin
      if (we) begin
        m_mem[wa] = wd;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
      if (fw) begin
        m_z = zi; m_s = si;
      end
    end
    #1;
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = 0;
    m_cnt = 0; m_z = 0; m_s = 0;
    Reset = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0; RdAddrA = '0;
    RdAddrB = '0; FlagWr = 1'b0; ZeroIn = 1'b0; SignIn = 1'b0;
    @(posedge Clk); #1;

    // Reset state on every address
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, i, 7 - i, 0, 0, 0, "reset_read");

    // Same-cycle forwarding then array read
    cycle(0, 1, 3, 8'h5A, 3, 0, 0, 0, 0, "fwd_r3");
    cycle(0, 0, 0, 0, 3, 3, 0, 0, 0, "hold_r3");

    // Two ports, then dual forward to same index
    cycle(0, 1, 1, 8'h01, 0, 0, 0, 0, 0, "wr_r1");
    cycle(0, 1, 2, 8'h02, 1, 0, 0, 0, 0, "wr_r2");
    cycle(0, 0, 0, 0, 1, 2, 0, 0, 0, "rd_r1_r2");
    cycle(0, 1, 1, 8'hFF, 1, 1, 0, 0, 0, "dual_fwd");
    cycle(0, 0, 0, 0, 1, 2, 0, 0, 0, "rd_after_dual");

    // Flag capture and hold
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 0, "flag_cap");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, "flag_hold");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, "flag_hold2");

    // Reset beats concurrent write and flag capture; forwarding still visible
    cycle(1, 1, 4, 8'h77, 4, 3, 1, 1, 0, "rst_prio");
    cycle(0, 0, 0, 0, 4, 3, 0, 0, 0, "after_rst");

    // Saturation: 260 consecutive writes
    for (int i = 0; i < 260; i++) cycle(0, 1, i % 8, (i * 37 + 5) % 256, (i + 3) % 8, i % 8, 0, 0, 0, "sat");
    cycle(0, 0, 0, 0, 259 % 8, 258 % 8, 0, 0, 0, "sat_last");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 1) == 1), "rand");
    end

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge Clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
